mem_read_arbiter: RTL and testbench

- Round-robin controller that shares the single address-match memory read port between two requesters, e.g. the gesture classifier and the display path.
- Accepts one request at a time and drives the memory's ADD input.
- Waits for the memory's CLR-low hit pulse, returns DATA to the winning requester, then holds off for the memory's post-hit stall window before serving the next request.
- A timeout guards against a memory that never produces a hit.

---
 rtl/mem_read_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_read_arbiter
// Function : Round-robin arbiter that shares one address-match memory read
//            port between two requesters. The winner's address is driven on
//            MEM_ADD, the CLR-low hit is qualified by a data match, and a
//            cooldown covers the memory's post-hit stall. Requests time out
//            when no hit arrives.
// Revision : 1.0 - initial release
// ============================================================================
module mem_read_arbiter #(
  parameter int AW       = 6,
  parameter int TIMEOUT  = 72,
  parameter int COOL_CYC = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic [AW-1:0] ADDR0,
  input  logic          REQ1,
  input  logic [AW-1:0] ADDR1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          RVALID0,
  output logic          RVALID1,
  output logic [AW-1:0] RDATA,
  output logic          RERR,
  output logic [AW-1:0] MEM_ADD,
  input  logic          MEM_CLR,
  input  logic [AW-1:0] MEM_DATA,
  output logic          BUSY
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int CW = $clog2(COOL_CYC + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] timer;
  logic [CW-1:0] cool_cnt;
  logic          last;
  logic          owner;
  logic          req_any;
  logic          sel;
  logic          hit;
  logic          expire;
  logic          done;

  // Request selection and WAIT exit conditions
  always_comb begin
    req_any = REQ0 | REQ1;
    // With both requesting, the one not served last wins; otherwise the lone requester
    sel     = (REQ0 && REQ1) ? ~last : REQ1;
    // The data qualifier rejects a CLR-low pulse left over from the previous address
    hit     = (state == S_WAIT) && !MEM_CLR && (MEM_DATA == MEM_ADD);
    expire  = (state == S_WAIT) && (timer == TW'(TIMEOUT - 1));
    done    = hit | expire;
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> WAIT -> COOL -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_any) state_nxt = S_WAIT;
      S_WAIT:  if (done) state_nxt = S_COOL;
      S_COOL:  if (cool_cnt <= CW'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    BUSY = (state != S_IDLE);
  end

  // Transaction datapath: grant, timer, response and cooldown registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      RVALID0  <= 1'b0;
      RVALID1  <= 1'b0;
      RDATA    <= '0;
      RERR     <= 1'b0;
      MEM_ADD  <= '0;
      timer    <= '0;
      cool_cnt <= '0;
      last     <= 1'b1;
      owner    <= 1'b0;
    end else begin
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            MEM_ADD <= sel ? ADDR1 : ADDR0;
            owner   <= sel;
            GNT0    <= ~sel;
            GNT1    <= sel;
            timer   <= '0;
          end
        end
        S_WAIT: begin
          if (done) begin
            // A hit in the timeout cycle still counts as a hit
            RDATA    <= hit ? MEM_DATA : '1;
            RERR     <= ~hit;
            RVALID0  <= ~owner;
            RVALID1  <= owner;
            GNT0     <= 1'b0;
            GNT1     <= 1'b0;
            last     <= owner;
            cool_cnt <= CW'(COOL_CYC);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COOL: begin
          cool_cnt <= cool_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`timescale 1ns/1ps
module tb_mem_read_arbiter;
  localparam int AW       = 6;
  localparam int TIMEOUT  = 72;
  localparam int COOL_CYC = 2;

  localparam int M_CNT  = 0;  // memory counter sweeping, CLR low when counter matches ADD
  localparam int M_HIGH = 1;  // CLR stuck high
  localparam int M_RAND = 2;  // random CLR, data biased toward ADD
  localparam int M_MAN  = 3;  // driven by hand

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ0 = 1'b0, REQ1 = 1'b0;
  logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
  logic          GNT0, GNT1, RVALID0, RVALID1, RERR, BUSY;
  logic [AW-1:0] RDATA, MEM_ADD;
  logic          MEM_CLR = 1'b1;
  logic [AW-1:0] MEM_DATA = '0;

  int checks = 0;
  int failures = 0;
  int mode = M_CNT;
  bit auto_req = 1'b0;
  bit chk_en = 1'b0;
  logic [AW-1:0] ctr = '0;

  mem_read_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT), .COOL_CYC(COOL_CYC)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .ADDR0(ADDR0), .REQ1(REQ1), .ADDR1(ADDR1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .RDATA(RDATA), .RERR(RERR), .MEM_ADD(MEM_ADD),
    .MEM_CLR(MEM_CLR), .MEM_DATA(MEM_DATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // owner = requester currently being served (-1 none); cool = stall cycles left
  int            m_owner, m_waited, m_cool;
  bit            m_last, m_gnt0, m_gnt1, m_rv0, m_rv1, m_rerr;
  logic [AW-1:0] m_add, m_rdata;

  function automatic int pick(input logic r0, input logic r1, input bit lst);
    if (r0 && r1) return lst ? 0 : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_owner <= -1; m_waited <= 0; m_cool <= 0; m_last <= 1'b1;
      m_gnt0 <= 0; m_gnt1 <= 0; m_rv0 <= 0; m_rv1 <= 0; m_rerr <= 0;
      m_add <= '0; m_rdata <= '0;
    end else begin
      m_rv0 <= 0;
      m_rv1 <= 0;
      if (m_cool > 0) begin
        m_cool <= m_cool - 1;
      end else if (m_owner >= 0) begin
        if ((!MEM_CLR && MEM_DATA == m_add) || m_waited == TIMEOUT - 1) begin
          if (!MEM_CLR && MEM_DATA == m_add) begin
            m_rdata <= MEM_DATA; m_rerr <= 0;
          end else begin
            m_rdata <= 6'd63; m_rerr <= 1;
          end
          if (m_owner == 0) m_rv0 <= 1; else m_rv1 <= 1;
          m_gnt0 <= 0; m_gnt1 <= 0;
          m_last <= (m_owner == 1);
          m_owner <= -1;
          m_cool <= COOL_CYC;
        end else begin
          m_waited <= m_waited + 1;
        end
      end else if (pick(REQ0, REQ1, m_last) >= 0) begin
        m_owner  <= pick(REQ0, REQ1, m_last);
        m_add    <= (pick(REQ0, REQ1, m_last) == 1) ? ADDR1 : ADDR0;
        m_gnt0   <= (pick(REQ0, REQ1, m_last) == 0);
        m_gnt1   <= (pick(REQ0, REQ1, m_last) == 1);
        m_waited <= 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en && !RST)
      check("model_cycle",
            32'({GNT0, GNT1, RVALID0, RVALID1, RERR, BUSY, RDATA, MEM_ADD}),
            32'({m_gnt0, m_gnt1, m_rv0, m_rv1, m_rerr, (m_owner >= 0 || m_cool > 0), m_rdata, m_add}));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_mem();
    case (mode)
      M_CNT: begin
        MEM_DATA = ctr;
        MEM_CLR  = (ctr == MEM_ADD) ? 1'b0 : 1'b1;
        ctr      = ctr + 1'b1;
      end
      M_HIGH: begin
        MEM_CLR  = 1'b1;
        MEM_DATA = AW'($urandom);
      end
      M_RAND: begin
        MEM_CLR  = 1'($urandom % 2);
        MEM_DATA = ($urandom % 3 == 0) ? MEM_ADD : AW'($urandom);
      end
      default: begin
      end
    endcase
  endtask

  task automatic drive_req();
    if (!auto_req) return;
    if (REQ0) begin
      if (RVALID0 || (GNT0 && $urandom % 16 == 0)) REQ0 = 1'b0;
    end else if ($urandom % 4 == 0) begin
      REQ0 = 1'b1; ADDR0 = AW'($urandom);
    end
    if (REQ1) begin
      if (RVALID1 || (GNT1 && $urandom % 16 == 0)) REQ1 = 1'b0;
    end else if ($urandom % 4 == 0) begin
      REQ1 = 1'b1; ADDR1 = AW'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    drive_mem();
    drive_req();
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0: return GNT0;
      1: return GNT1;
      2: return RVALID0;
      default: return RVALID1;
    endcase
  endfunction

  // Advance until the selected output is high; n = cycles taken
  task automatic wait_sig(input int which, input int maxc, output int n);
    n = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (sig_of(which)) begin
        n = i + 1;
        break;
      end
    end
    if (n < 0) check("wait_bound_expired", 32'(which), 32'hFFFF);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    RST = 1'b1;
    #1;
    check("reset_outputs",
          32'({GNT0, GNT1, RVALID0, RVALID1, RERR, BUSY, RDATA, MEM_ADD}), 32'd0);
    repeat (2) tick();
    RST = 1'b0;
    ctr = '0;
    chk_en = 1'b1;
  endtask

  int n;
  int who;

  initial begin
    // Reset and single request, real counter memory
    do_reset();
    mode = M_CNT;
    REQ0 = 1'b1; ADDR0 = 6'd5;
    wait_sig(0, 5, n);
    check("t1_grant_latency", 32'(n), 32'd1);
    check("t1_mem_add", 32'(MEM_ADD), 32'd5);
    wait_sig(2, 100, n);
    check("t1_rdata", 32'(RDATA), 32'd5);
    check("t1_rerr", 32'(RERR), 32'd0);
    REQ0 = 1'b0;
    tick();
    check("t1_busy_cool", 32'(BUSY), 32'd1);
    tick();
    check("t1_busy_idle", 32'(BUSY), 32'd0);

    // Simultaneous requests after reset: requester 0 first
    do_reset();
    mode = M_CNT;
    REQ0 = 1'b1; ADDR0 = 6'd10;
    REQ1 = 1'b1; ADDR1 = 6'd20;
    wait_sig(2, 150, n);
    check("t2_rdata0", 32'(RDATA), 32'd10);
    REQ0 = 1'b0;
    wait_sig(1, 10, n);
    check("t2_gnt1_spacing", 32'(n), 32'(COOL_CYC + 1));
    wait_sig(3, 150, n);
    check("t2_rdata1", 32'(RDATA), 32'd20);
    REQ1 = 1'b0;
    repeat (4) tick();

    // Timeout with CLR stuck high
    mode = M_HIGH;
    REQ0 = 1'b1; ADDR0 = 6'd33;
    wait_sig(0, 5, n);
    wait_sig(2, 100, n);
    check("t3_timeout_cycles", 32'(n), 32'd72);
    check("t3_rdata", 32'(RDATA), 32'd63);
    check("t3_rerr", 32'(RERR), 32'd1);
    REQ0 = 1'b0;
    repeat (4) tick();

    // Stale hit with wrong data is ignored, later matching hit completes
    mode = M_MAN;
    MEM_CLR = 1'b1;
    REQ0 = 1'b1; ADDR0 = 6'd12;
    wait_sig(0, 5, n);
    MEM_CLR = 1'b0; MEM_DATA = 6'd7;
    repeat (3) tick();
    check("t4_stale_ignored", 32'({RVALID0, GNT0}), 32'b01);
    MEM_DATA = 6'd12;
    tick();
    check("t4_hit_rvalid", 32'(RVALID0), 32'd1);
    check("t4_hit_rdata", 32'(RDATA), 32'd12);
    check("t4_hit_rerr", 32'(RERR), 32'd0);
    MEM_CLR = 1'b1;
    REQ0 = 1'b0;
    repeat (4) tick();

    // Reset mid-WAIT: outputs clear at once, held REQ1 re-granted
    mode = M_HIGH;
    REQ1 = 1'b1; ADDR1 = 6'd44;
    wait_sig(1, 5, n);
    repeat (10) tick();
    chk_en = 1'b0;
    RST = 1'b1;
    #1;
    check("t5_reset_mid_wait",
          32'({GNT0, GNT1, RVALID0, RVALID1, RERR, BUSY, RDATA, MEM_ADD}), 32'd0);
    tick();
    check("t5_no_rvalid", 32'({RVALID0, RVALID1}), 32'd0);
    RST = 1'b0;
    chk_en = 1'b1;
    mode = M_CNT;
    ctr = '0;
    wait_sig(1, 5, n);
    check("t5_regrant_latency", 32'(n), 32'd1);
    wait_sig(3, 100, n);
    check("t5_rdata", 32'(RDATA), 32'd44);
    REQ1 = 1'b0;
    repeat (4) tick();

    // Fairness: both held high, grants alternate 0,1,0,1,0,1
    mode = M_RAND;
    REQ0 = 1'b1; ADDR0 = 6'd3;
    REQ1 = 1'b1; ADDR1 = 6'd50;
    for (int k = 0; k < 6; k++) begin
      who = -1;
      for (int c = 0; c < 500; c++) begin
        tick();
        if (RVALID0 || RVALID1) begin
          who = RVALID1 ? 1 : 0;
          break;
        end
      end
      check("t6_grant_order", 32'(who), 32'(k % 2));
      check("t6_rdata", 32'(RDATA), (k % 2 == 1) ? 32'd50 : 32'd3);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (4) tick();

    // Randomized traffic against the model
    auto_req = 1'b1;
    for (int blk = 0; blk < 6; blk++) begin
      mode = (blk % 3 == 2) ? M_CNT : M_RAND;
      repeat (500) tick();
    end
    auto_req = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (100) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
